fpu_dram_responder: RTL and testbench

DRAM-side end of the FPU/DRAM request handshake.
- Accepts single-beat 64-bit read/write requests from the FPU request controller over the fpu_ready/dram_ready handshake.
- Services each request from an internal word-addressed memory after a fixed, parameterised busy latency.
- Replaces behavioural DRAM stubs in FPU memory-path integration and acts as the on-chip DRAM model for system simulation.

---
 rtl/fpu_dram_pkg.sv | 23 ++
 rtl/fpu_dram_mem_array.sv | 29 ++
 rtl/fpu_dram_responder.sv | 133 +++++++++++++
 tb/tb_fpu_dram_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_dram_pkg.sv
// Shared types and constants for the FPU-facing DRAM responder.
// Holds the request latch layout and the op encoding.
package fpu_dram_pkg;

    localparam int DRAM_DATA_WIDTH = 64;
    localparam int DRAM_IDX_WIDTH  = 32;

    localparam logic DRAM_OP_READ  = 1'b0;
    localparam logic DRAM_OP_WRITE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dram_state_e;

    typedef struct packed {
        logic                       op;
        logic [DRAM_IDX_WIDTH-1:0]  index;
        logic [DRAM_DATA_WIDTH-1:0] data;
        logic                       misaligned;
    } dram_req_t;

endpackage

// File: rtl/fpu_dram_mem_array.sv
// Single-port synchronous RAM with registered read data.
// Contents are left uninitialised; only the read register is state here.
module fpu_dram_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fpu_dram_responder.sv
// DRAM end of the FPU request handshake: one request in flight,
// completed from the internal RAM after a fixed busy latency.
module fpu_dram_responder
    import fpu_dram_pkg::*;
#(
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fpu_ready,
    input  logic                  fpu_op,
    input  logic [31:0]           fpu_address,
    input  logic [DATA_WIDTH-1:0] fpu_wr_data,
    output logic                  dram_ready,
    output logic [DATA_WIDTH-1:0] dram_rd_data,
    output logic                  dram_rd_valid,
    output logic                  addr_err
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("fpu_dram_responder: LATENCY must be in 1..255");
    end
    if (DATA_WIDTH > DRAM_DATA_WIDTH) begin : g_bad_width
        $error("fpu_dram_responder: DATA_WIDTH exceeds request latch");
    end

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    dram_state_e           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    dram_req_t             req_q, req_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  addr_err_q, addr_err_d;

    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-1:0] idx_in;
    logic                  unused_bits;

    assign idx_in      = fpu_address[ADDR_WIDTH+2:3];
    assign unused_bits = ^{fpu_address[31:ADDR_WIDTH+3],
                           req_q.index[DRAM_IDX_WIDTH-1:ADDR_WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fpu_ready) begin
                    req_d.op         = fpu_op;
                    req_d.index      = DRAM_IDX_WIDTH'(idx_in);
                    req_d.data       = DRAM_DATA_WIDTH'(fpu_wr_data);
                    req_d.misaligned = |fpu_address[2:0];
                    cnt_d            = LAT_M1;
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (req_q.op == DRAM_OP_READ) begin
                        rd_data_d  = mem_rdata;
                        rd_valid_d = 1'b1;
                    end
                    addr_err_d = req_q.misaligned;
                    state_d    = IDLE;
                end
            end
        endcase
    end

    // Read is launched one cycle before completion so the RAM's
    // registered output is ready on the completing edge.
    always_comb begin
        dram_ready = (state_q == IDLE);
        mem_we     = (state_q == BUSY) && (cnt_q == 8'd0)
                     && (req_q.op == DRAM_OP_WRITE);
        if (LATENCY == 1) begin
            mem_re = (state_q == IDLE) && fpu_ready
                     && (fpu_op == DRAM_OP_READ);
        end else begin
            mem_re = (state_q == BUSY) && (cnt_q == 8'd1)
                     && (req_q.op == DRAM_OP_READ);
        end
        mem_addr = (state_q == IDLE) ? idx_in
                                     : req_q.index[ADDR_WIDTH-1:0];
    end

    fpu_dram_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(req_q.data[DATA_WIDTH-1:0]),
        .rdata(mem_rdata)
    );

    assign dram_rd_data  = rd_data_q;
    assign dram_rd_valid = rd_valid_q;
    assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_fpu_dram_responder.sv
// Directed bench for fpu_dram_responder at LATENCY 4 and LATENCY 1.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fpu_dram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        fpu_ready = 1'b0;
    logic        fpu_op = 1'b0;
    logic [31:0] fpu_address = '0;
    logic [63:0] fpu_wr_data = '0;
    logic        dram_ready;
    logic [63:0] dram_rd_data;
    logic        dram_rd_valid;
    logic        addr_err;

    logic        f1_ready = 1'b0;
    logic        f1_op = 1'b0;
    logic [31:0] f1_address = '0;
    logic [63:0] f1_wr_data = '0;
    logic        d1_ready;
    logic [63:0] d1_rd_data;
    logic        d1_rd_valid;
    logic        d1_addr_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_dram_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(10), .LATENCY(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fpu_ready(fpu_ready), .fpu_op(fpu_op),
        .fpu_address(fpu_address), .fpu_wr_data(fpu_wr_data),
        .dram_ready(dram_ready), .dram_rd_data(dram_rd_data),
        .dram_rd_valid(dram_rd_valid), .addr_err(addr_err)
    );

    fpu_dram_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(10), .LATENCY(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .fpu_ready(f1_ready), .fpu_op(f1_op),
        .fpu_address(f1_address), .fpu_wr_data(f1_wr_data),
        .dram_ready(d1_ready), .dram_rd_data(d1_rd_data),
        .dram_rd_valid(d1_rd_valid), .addr_err(d1_addr_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on dut and stop in its completion cycle.
    task automatic do_req(input logic op, input logic [31:0] addr,
                          input logic [63:0] wd, output logic rv,
                          output logic ae, output logic [63:0] rd);
        int k;
        fpu_ready = 1'b1;
        fpu_op = op;
        fpu_address = addr;
        fpu_wr_data = wd;
        step();
        fpu_ready = 1'b0;
        k = 0;
        while (!dram_ready && k < 50) begin
            step();
            k++;
        end
        checks++;
        if (!dram_ready) begin
            errors++;
            $display("FAIL req_timeout addr=%h got ready=%b want 1",
                     addr, dram_ready);
        end
        rv = dram_rd_valid;
        ae = addr_err;
        rd = dram_rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks += 5;
        if (dram_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %b want 1", dram_ready);
        end
        if (dram_rd_data !== 64'h0) begin
            errors++;
            $display("FAIL rst_data got %h want 0", dram_rd_data);
        end
        if (dram_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b want 0", dram_rd_valid);
        end
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_err got %b want 0", addr_err);
        end
        if (d1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready1 got %b want 1", d1_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        logic rv, ae;
        logic [63:0] rd;
        do_req(1'b1, 32'h40, 64'hDEADBEEF_CAFEF00D, rv, ae, rd);
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL wr_novalid got %b want 0", rv);
        end
        do_req(1'b0, 32'h40, 64'h0, rv, ae, rd);
        checks += 3;
        if (rv !== 1'b1) begin
            errors++;
            $display("FAIL rd_valid got %b want 1", rv);
        end
        if (rd !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL rd_data got %h want deadbeefcafef00d", rd);
        end
        if (ae !== 1'b0) begin
            errors++;
            $display("FAIL rd_err got %b want 0", ae);
        end
        step();
        checks++;
        if (dram_rd_valid !== 1'b0 ||
            dram_rd_data !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL rd_hold got v=%b d=%h want v=0 d=deadbeefcafef00d",
                     dram_rd_valid, dram_rd_data);
        end
    endtask

    task automatic test_latency();
        fpu_ready = 1'b1;
        fpu_op = 1'b0;
        fpu_address = 32'h40;
        step();
        fpu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dram_ready !== 1'b0) begin
                errors++;
                $display("FAIL lat4_busy%0d got %b want 0", i, dram_ready);
            end
            step();
        end
        checks++;
        if (dram_ready !== 1'b1 || dram_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat4_done got r=%b v=%b want r=1 v=1",
                     dram_ready, dram_rd_valid);
        end
    endtask

    task automatic test_latency1();
        f1_ready = 1'b1;
        f1_op = 1'b1;
        f1_address = 32'h8;
        f1_wr_data = 64'hABC;
        step();
        f1_ready = 1'b0;
        checks++;
        if (d1_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat1_wbusy got %b want 0", d1_ready);
        end
        step();
        checks++;
        if (d1_ready !== 1'b1 || d1_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat1_wdone got r=%b v=%b want r=1 v=0",
                     d1_ready, d1_rd_valid);
        end
        f1_ready = 1'b1;
        f1_op = 1'b0;
        step();
        f1_ready = 1'b0;
        checks++;
        if (d1_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat1_rbusy got %b want 0", d1_ready);
        end
        step();
        checks++;
        if (d1_ready !== 1'b1 || d1_rd_valid !== 1'b1 ||
            d1_rd_data !== 64'hABC) begin
            errors++;
            $display("FAIL lat1_rdone got r=%b v=%b d=%h want 1 1 abc",
                     d1_ready, d1_rd_valid, d1_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc, n_done, last_acc, cyc;
        logic [63:0] exp;
        n_acc = 0;
        n_done = 0;
        last_acc = 0;
        cyc = 0;
        while (n_done < 16 && cyc < 200) begin
            if (dram_ready) begin
                if (n_acc > n_done) begin
                    if (n_done >= 8) begin
                        exp = 64'(n_done - 8) * 64'h1111;
                        checks++;
                        if (dram_rd_valid !== 1'b1 || dram_rd_data !== exp) begin
                            errors++;
                            $display("FAIL b2b_rd%0d got v=%b d=%h want v=1 d=%h",
                                     n_done - 8, dram_rd_valid, dram_rd_data, exp);
                        end
                    end
                    n_done++;
                end
                if (n_acc < 16) begin
                    fpu_ready = 1'b1;
                    fpu_op = (n_acc < 8);
                    fpu_address = 32'((n_acc % 8) * 8);
                    fpu_wr_data = 64'(n_acc % 8) * 64'h1111;
                    if (n_acc > 0) begin
                        checks++;
                        if (cyc + 1 - last_acc != 5) begin
                            errors++;
                            $display("FAIL b2b_gap%0d got %0d want 5",
                                     n_acc, cyc + 1 - last_acc);
                        end
                    end
                    last_acc = cyc + 1;
                    n_acc++;
                end else begin
                    fpu_ready = 1'b0;
                end
            end
            step();
            cyc++;
        end
        fpu_ready = 1'b0;
        checks++;
        if (n_done != 16) begin
            errors++;
            $display("FAIL b2b_timeout got %0d done want 16", n_done);
        end
        while (!dram_ready && cyc < 250) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_ignored_busy();
        int k;
        logic rv, ae;
        logic [63:0] rd;
        fpu_ready = 1'b1;
        fpu_op = 1'b0;
        fpu_address = 32'h40;
        step();
        fpu_ready = 1'b0;
        fpu_op = 1'b1;
        fpu_address = 32'h0;
        fpu_wr_data = 64'hFFFF_FFFF;
        k = 0;
        while (!dram_ready && k < 50) begin
            step();
            k++;
        end
        checks++;
        if (dram_rd_valid !== 1'b1 ||
            dram_rd_data !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL busy_latched got v=%b d=%h want v=1 d=deadbeefcafef00d",
                     dram_rd_valid, dram_rd_data);
        end
        do_req(1'b0, 32'h0, 64'h0, rv, ae, rd);
        checks++;
        if (rv !== 1'b1 || rd !== 64'h0) begin
            errors++;
            $display("FAIL busy_nowrite got v=%b d=%h want v=1 d=0", rv, rd);
        end
    endtask

    task automatic test_misaligned_alias();
        logic rv, ae;
        logic [63:0] rd;
        do_req(1'b0, 32'h43, 64'h0, rv, ae, rd);
        checks += 2;
        if (rd !== 64'hDEADBEEF_CAFEF00D || rv !== 1'b1) begin
            errors++;
            $display("FAIL mis_data got v=%b d=%h want v=1 d=deadbeefcafef00d",
                     rv, rd);
        end
        if (ae !== 1'b1) begin
            errors++;
            $display("FAIL mis_err got %b want 1", ae);
        end
        step();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse got %b want 0", addr_err);
        end
        do_req(1'b0, 32'h2040, 64'h0, rv, ae, rd);
        checks += 2;
        if (rd !== 64'hDEADBEEF_CAFEF00D || rv !== 1'b1) begin
            errors++;
            $display("FAIL alias_data got v=%b d=%h want v=1 d=deadbeefcafef00d",
                     rv, rd);
        end
        if (ae !== 1'b0) begin
            errors++;
            $display("FAIL alias_err got %b want 0", ae);
        end
    endtask

    task automatic test_reset_mid();
        logic rv, ae;
        logic [63:0] rd;
        do_req(1'b1, 32'h80, 64'h5555, rv, ae, rd);
        fpu_ready = 1'b1;
        fpu_op = 1'b1;
        fpu_address = 32'h80;
        fpu_wr_data = 64'h1234;
        step();
        fpu_ready = 1'b0;
        step();
        checks++;
        if (dram_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_busy got %b want 0", dram_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dram_ready !== 1'b1 || dram_rd_data !== 64'h0) begin
            errors++;
            $display("FAIL rmid_async got r=%b d=%h want r=1 d=0",
                     dram_ready, dram_rd_data);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        do_req(1'b0, 32'h80, 64'h0, rv, ae, rd);
        checks++;
        if (rv !== 1'b1 || rd !== 64'h5555) begin
            errors++;
            $display("FAIL rmid_keep got v=%b d=%h want v=1 d=5555", rv, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        step();
        test_latency1();
        test_back_to_back();
        test_ignored_busy();
        test_misaligned_alias();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
